// File: rtl/plot_arbiter.sv
// Round-robin arbiter that shares the VGA pixel-write port between N_REQ rectangle-fill
// requesters. It rasterises the winner's rectangle at one pixel per cycle and clips pixels that fall off screen.
module plot_arbiter #(
  parameter int unsigned N_REQ = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_x,
  input  logic [7*N_REQ-1:0] req_y,
  input  logic [4*N_REQ-1:0] req_w,
  input  logic [4*N_REQ-1:0] req_h,
  input  logic [3*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               plot
);
  localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned X_MAX = 159;
  localparam int unsigned Y_MAX = 119;

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   last_grant, last_grant_d;
  logic [IW-1:0]   winner, winner_d;
  logic [7:0]      bx, bx_d;
  logic [6:0]      by, by_d;
  logic [3:0]      bw, bw_d, bh, bh_d;
  logic [3:0]      cx, cx_d, cy, cy_d;
  logic [2:0]      bc, bc_d;
  logic [N_REQ-1:0] ack_d, done_d;
  logic            busy_d, plot_d;
  logic [7:0]      x_d;
  logic [6:0]      y_d;
  logic [2:0]      colour_d;

  logic [7:0] gx [N_REQ];
  logic [6:0] gy [N_REQ];
  logic [3:0] gw [N_REQ];
  logic [3:0] gh [N_REQ];
  logic [2:0] gc [N_REQ];

  // Unpack per-requester geometry slices
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gx[i] = req_x[8*i +: 8];
      gy[i] = req_y[7*i +: 7];
      gw[i] = req_w[4*i +: 4];
      gh[i] = req_h[4*i +: 4];
      gc[i] = req_colour[3*i +: 3];
    end
  end

  // Round-robin search starting just after the last granted requester
  logic          grant_found;
  logic [IW-1:0] grant_idx;
  int unsigned   cand;
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    cand        = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_grant) + k) % N_REQ;
      if (!grant_found && req[IW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // Wide sums so off-screen pixels are detected instead of wrapping
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       in_bounds;
  assign x_sum     = {1'b0, bx} + {5'b0, cx};
  assign y_sum     = {1'b0, by} + {4'b0, cy};
  assign in_bounds = (x_sum <= 9'(X_MAX)) && (y_sum <= 8'(Y_MAX));

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    winner_d     = winner;
    bx_d = bx; by_d = by; bw_d = bw; bh_d = bh; bc_d = bc;
    cx_d = cx; cy_d = cy;
    ack_d    = '0;
    done_d   = '0;
    busy_d   = 1'b0;
    plot_d   = 1'b0;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          state_d  = S_DRAW;
          ack_d    = N_REQ'(1) << grant_idx;
          busy_d   = 1'b1;
          winner_d = grant_idx;
          bx_d     = gx[grant_idx];
          by_d     = gy[grant_idx];
          bw_d     = gw[grant_idx];
          bh_d     = gh[grant_idx];
          bc_d     = gc[grant_idx];
          cx_d     = '0;
          cy_d     = '0;
        end
      end
      S_DRAW: begin
        busy_d = 1'b1;
        plot_d = in_bounds;
        if (in_bounds) begin
          x_d      = x_sum[7:0];
          y_d      = y_sum[6:0];
          colour_d = bc;
        end
        if (cx == bw) begin
          cx_d = '0;
          cy_d = cy + 4'd1;
          if (cy == bh) state_d = S_DONE;
        end else begin
          cx_d = cx + 4'd1;
        end
      end
      S_DONE: begin
        // busy stays high through the done cycle so it spans ack..done
        busy_d       = 1'b1;
        done_d       = N_REQ'(1) << winner;
        last_grant_d = winner;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      last_grant <= IW'(N_REQ - 1);
      winner     <= '0;
      bx <= '0; by <= '0; bw <= '0; bh <= '0; bc <= '0;
      cx <= '0; cy <= '0;
      ack    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      winner     <= winner_d;
      bx <= bx_d; by <= by_d; bw <= bw_d; bh <= bh_d; bc <= bc_d;
      cx <= cx_d; cy <= cy_d;
      ack    <= ack_d;
      done   <= done_d;
      busy   <= busy_d;
      plot   <= plot_d;
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
    end
  end
endmodule

// File: tb/tb_plot_arbiter.sv
// Randomised bench for plot_arbiter: a transaction-level schedule model predicts every
// output cycle, and directed scenarios pin the model with hand-computed values.
module tb_plot_arbiter;
  localparam int unsigned N = 3;

  logic           clock = 1'b0;
  logic           resetn;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_x;
  logic [7*N-1:0] req_y;
  logic [4*N-1:0] req_w;
  logic [4*N-1:0] req_h;
  logic [3*N-1:0] req_colour;
  logic [N-1:0]   ack, done;
  logic           busy, plot;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;

  plot_arbiter #(.N_REQ(N)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .ack(ack), .done(done),
    .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clock = ~clock;

  typedef struct {int ack; int done; int busy; int plot; int x; int y; int c;} exp_t;
  typedef struct {int cyc; int x; int y; int c;} pix_t;
  typedef struct {int cyc; int idx;} ev_t;

  exp_t exp_q[$];
  pix_t plot_log[$];
  ev_t  ack_log[$], done_log[$];
  int   cyc = 0, checks = 0, errors = 0, busy_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: a grant schedules the whole transaction's outputs, cycle by cycle
  int m_lg = N - 1;
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!resetn) begin
      exp_q.delete();
      m_lg = N - 1;
    end else if (exp_q.size() == 0 && req != 0) begin
      int win, bx, by, bw, bh, bc;
      exp_t e;
      win = -1;
      for (int k = 1; k <= int'(N); k++) begin
        int c;
        c = (m_lg + k) % N;
        if (win < 0 && req[c]) win = c;
      end
      bx = int'(req_x[8*win +: 8]); by = int'(req_y[7*win +: 7]);
      bw = int'(req_w[4*win +: 4]); bh = int'(req_h[4*win +: 4]);
      bc = int'(req_colour[3*win +: 3]);
      e = '{ack: 1 << win, done: 0, busy: 1, plot: 0, x: 0, y: 0, c: 0};
      exp_q.push_back(e);
      for (int r = 0; r <= bh; r++)
        for (int col = 0; col <= bw; col++) begin
          e = '{ack: 0, done: 0, busy: 1, x: bx + col, y: by + r, c: bc,
                plot: ((bx + col) <= 159 && (by + r) <= 119) ? 1 : 0};
          exp_q.push_back(e);
        end
      e = '{ack: 0, done: 1 << win, busy: 1, plot: 0, x: 0, y: 0, c: 0};
      exp_q.push_back(e);
      m_lg = win;
    end
  end

  // Compare process: every cycle against the model schedule
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{ack: 0, done: 0, busy: 0, plot: 0, x: 0, y: 0, c: 0};
    chk("ack", ack, e.ack);
    chk("done", done, e.done);
    chk("busy", busy, e.busy);
    chk("plot", plot, e.plot);
    if (e.plot != 0) begin
      chk("x", x, e.x);
      chk("y", y, e.y);
      chk("colour", colour, e.c);
    end
    if (busy === 1'b1) busy_cnt++;
    if (ack != 0) ack_log.push_back('{cyc: cyc, idx: oh2i(ack)});
    if (done != 0) done_log.push_back('{cyc: cyc, idx: oh2i(done)});
    if (plot === 1'b1) plot_log.push_back('{cyc: cyc, x: int'(x), y: int'(y), c: int'(colour)});
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic rand_geom();
    req_x = 24'($urandom); req_y = 21'($urandom); req_w = 12'($urandom);
    req_h = 12'($urandom); req_colour = 9'($urandom);
    for (int i = 0; i < int'(N); i++) req_x[8*i +: 8] = 8'($urandom_range(0, 175));
    for (int i = 0; i < int'(N); i++) req_y[7*i +: 7] = 7'($urandom_range(0, 127));
  endtask

  task automatic set_geom(input int i, input int gx, input int gy, input int gw, input int gh, input int gc);
    req_x[8*i +: 8] = 8'(gx); req_y[7*i +: 7] = 7'(gy);
    req_w[4*i +: 4] = 4'(gw); req_h[4*i +: 4] = 4'(gh); req_colour[3*i +: 3] = 3'(gc);
  endtask

  task automatic wait_ack();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (ack != 0) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL ack_timeout: no ack within 600 cycles"); end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (done != 0) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL done_timeout: no done within 600 cycles"); end
  endtask

  task automatic clear_logs();
    plot_log.delete(); ack_log.delete(); done_log.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex[4], ey[4];
    int ord[6];
    resetn = 1'b0; req = '0;
    rand_geom();
    tick(); tick();
    chk("rst_x", x, 0); chk("rst_y", y, 0); chk("rst_colour", colour, 0);
    chk("rst_plot", plot, 0); chk("rst_ack", ack, 0); chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    tick();

    // Single 2x2 rectangle from requester 1
    ex = '{10, 11, 10, 11}; ey = '{20, 20, 21, 21};
    clear_logs();
    set_geom(1, 10, 20, 1, 1, 3);
    req = 3'b010;
    wait_ack();
    chk("d1_ack", ack, 3'b010);
    req = '0;
    wait_done();
    chk("d1_done", done, 3'b010);
    chk("d1_npix", plot_log.size(), 4);
    if (plot_log.size() == 4 && ack_log.size() > 0 && done_log.size() > 0) begin
      for (int i = 0; i < 4; i++) begin
        chk("d1_px", plot_log[i].x, ex[i]);
        chk("d1_py", plot_log[i].y, ey[i]);
        chk("d1_pc", plot_log[i].c, 3);
      end
      chk("d1_latency", plot_log[0].cyc - ack_log[0].cyc, 1);
      chk("d1_done_after_last", done_log[0].cyc - plot_log[3].cyc, 1);
    end

    // All three held: round-robin from requester 0
    do_reset();
    clear_logs();
    for (int i = 0; i < int'(N); i++) set_geom(i, 5 * i, 3 * i, 0, 0, i + 1);
    req = 3'b111;
    for (int i = 0; i < 300 && done_log.size() < 6; i++) tick();
    req = '0;
    ord = '{0, 1, 2, 0, 1, 2};
    chk("d2_ngrants", ack_log.size() >= 6 && plot_log.size() >= 6, 1);
    if (ack_log.size() >= 6 && done_log.size() >= 6 && plot_log.size() >= 6)
      for (int t = 0; t < 6; t++) begin
        chk("d2_order", ack_log[t].idx, ord[t]);
        if (t > 0) begin
          chk("d2_done_to_ack", ack_log[t].cyc - done_log[t-1].cyc, 1);
          chk("d2_plot_gap", plot_log[t].cyc - plot_log[t-1].cyc, 3);
        end
      end
    for (int i = 0; i < 10; i++) tick();

    // Clipping at the bottom-right corner
    clear_logs();
    set_geom(0, 158, 119, 3, 1, 5);
    req = 3'b001;
    wait_ack();
    req = '0;
    wait_done();
    chk("d3_npix", plot_log.size(), 2);
    if (plot_log.size() == 2 && ack_log.size() > 0 && done_log.size() > 0) begin
      chk("d3_p0x", plot_log[0].x, 158); chk("d3_p0y", plot_log[0].y, 119);
      chk("d3_p1x", plot_log[1].x, 159); chk("d3_p1y", plot_log[1].y, 119);
      chk("d3_len", done_log[0].cyc - ack_log[0].cyc, 9);
    end

    // Largest rectangle
    tick();
    clear_logs();
    busy_cnt = 0;
    set_geom(2, 0, 0, 15, 15, 7);
    req = 3'b100;
    wait_ack();
    req = '0;
    wait_done();
    for (int i = 0; i < 4; i++) tick();
    chk("d4_npix", plot_log.size(), 256);
    if (plot_log.size() == 256) chk("d4_consec", plot_log[255].cyc - plot_log[0].cyc, 255);
    chk("d4_busy", busy_cnt, 258);

    // Reset in the 5th DRAW cycle
    clear_logs();
    set_geom(1, 20, 20, 3, 3, 2);
    req = 3'b010;
    wait_ack();
    req = '0;
    for (int i = 0; i < 4; i++) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("d5_plot", plot, 0);
    chk("d5_busy", busy, 0);
    for (int i = 0; i < 25; i++) tick();
    chk("d5_nodone", done_log.size(), 0);
    rand_geom();
    req = 3'b101;
    wait_ack();
    chk("d5_ack0", ack, 3'b001);
    req = 3'b100;
    wait_done();
    wait_ack();
    req = '0;
    wait_done();

    // Random traffic with occasional resets
    for (int n = 0; n < 5000; n++) begin
      tick();
      rand_geom();
      for (int i = 0; i < int'(N); i++) begin
        if ($urandom_range(0, 3) != 0) req_w[4*i +: 4] = 4'($urandom_range(0, 5));
        if ($urandom_range(0, 3) != 0) req_h[4*i +: 4] = 4'($urandom_range(0, 5));
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
      end
      resetn = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
    end
    resetn = 1'b1;
    req = '0;
    for (int i = 0; i < 600 && (busy !== 1'b0 || exp_q.size() != 0); i++) tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
